// File: rtl/glitch_pkg.sv
// Shared types and LFSR definition for the multi-channel glitch injector.
package glitch_pkg;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    RAND  = 2'd1,
    XOR   = 2'd2,
    STUCK = 2'd3
  } glitch_mode_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    DELAY  = 3'd2,
    INJECT = 3'd3,
    DONE   = 3'd4
  } glitch_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/glitch_injector_multi_lfsr.sv
// Free-running 32-bit Galois LFSR used as the random corruption source.
module glitch_lfsr
  import glitch_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd17
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] q
);

  localparam logic [31:0] INIT = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= INIT;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/glitch_injector_multi.sv
// Inline register stage on CHANNELS buses that corrupts selected channels in a
// scheduled window (delay, duration, repeats) after arm/trigger.
module glitch_injector_multi
  import glitch_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SEED     = 17,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in,
  output logic [CHANNELS*WIDTH-1:0] out,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       chan_sel,
  input  logic [WIDTH-1:0]          mask,
  input  logic [CNT_W-1:0]          delay,
  input  logic [CNT_W-1:0]          duration,
  input  logic [7:0]                repeats,
  input  logic                      arm,
  input  logic                      trigger,
  input  logic                      abort,
  output logic                      busy,
  output logic                      injecting,
  output logic                      done,
  output logic [CNT_W-1:0]          glitch_count
);

  glitch_state_e            state_q, state_d;
  glitch_mode_e             mode_q, mode_d;
  logic [CHANNELS-1:0]      sel_q, sel_d;
  logic [WIDTH-1:0]         mask_q, mask_d;
  logic [CNT_W-1:0]         delay_q, delay_d;
  logic [CNT_W-1:0]         dur_q, dur_d;
  logic [7:0]               rep_cfg_q, rep_cfg_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               rep_q, rep_d;
  logic [CNT_W-1:0]         gcount_q, gcount_d;
  logic                     busy_q, busy_d;
  logic                     inj_q, inj_d;
  logic                     done_q, done_d;
  logic [CHANNELS*WIDTH-1:0] out_q, out_d;
  logic [31:0]              lfsr;

  glitch_lfsr #(.SEED(32'(SEED))) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  if (WIDTH < 32) begin : g_lfsr_hi
    logic lfsr_hi_unused;
    assign lfsr_hi_unused = ^lfsr[31:WIDTH];
  end

  // Schedule FSM, configuration latch and injection counter.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    delay_d   = delay_q;
    dur_d     = dur_q;
    rep_cfg_d = rep_cfg_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    gcount_d  = gcount_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (arm) begin
          state_d   = ARMED;
          mode_d    = glitch_mode_e'(mode);
          sel_d     = chan_sel;
          mask_d    = mask;
          delay_d   = delay;
          dur_d     = (duration == '0) ? CNT_W'(1) : duration;
          rep_cfg_d = (repeats == 8'd0) ? 8'd1 : repeats;
          gcount_d  = '0;
        end
        ARMED: if (trigger) begin
          rep_d = rep_cfg_q;
          if (delay_q != '0) begin
            state_d = DELAY;
            cnt_d   = delay_q - CNT_W'(1);
          end else begin
            state_d = INJECT;
            cnt_d   = dur_q - CNT_W'(1);
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_d = INJECT;
            cnt_d   = dur_q - CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        INJECT: begin
          if (gcount_q != '1) gcount_d = gcount_q + CNT_W'(1);
          if (cnt_q == '0) begin
            rep_d = rep_q - 8'd1;
            if (rep_q == 8'd1) begin
              state_d = DONE;
            end else if (delay_q != '0) begin
              state_d = DELAY;
              cnt_d   = delay_q - CNT_W'(1);
            end else begin
              cnt_d = dur_q - CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_q != IDLE) && !abort;
    inj_d  = (state_q == INJECT) && !abort;
    done_d = (state_q == DONE) && !abort;
  end

  // Per-channel corruption, keyed off the registered injecting flag.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic             hit;
    logic [WIDTH-1:0] g_c;
    logic [WIDTH-1:0] o_c;
    always_comb begin
      hit = inj_q && sel_q[c];
      g_c = '0;
      if (hit) begin
        case (mode_q)
          RAND:    g_c = lfsr[WIDTH-1:0];
          XOR:     g_c = mask_q;
          default: g_c = '0;
        endcase
      end
      if (hit && (mode_q == STUCK)) o_c = mask_q;
      else                          o_c = in[c*WIDTH +: WIDTH] ^ g_c;
    end
    assign out_d[c*WIDTH +: WIDTH] = o_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= PASS;
      sel_q     <= '0;
      mask_q    <= '0;
      delay_q   <= '0;
      dur_q     <= '0;
      rep_cfg_q <= '0;
      cnt_q     <= '0;
      rep_q     <= '0;
      gcount_q  <= '0;
      busy_q    <= 1'b0;
      inj_q     <= 1'b0;
      done_q    <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      delay_q   <= delay_d;
      dur_q     <= dur_d;
      rep_cfg_q <= rep_cfg_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      gcount_q  <= gcount_d;
      busy_q    <= busy_d;
      inj_q     <= inj_d;
      done_q    <= done_d;
      out_q     <= out_d;
    end
  end

  assign out          = out_q;
  assign busy         = busy_q;
  assign injecting    = inj_q;
  assign done         = done_q;
  assign glitch_count = gcount_q;

endmodule

// File: tb/tb_glitch_injector_multi.sv
// Scoreboard bench for glitch_injector_multi: a schedule-level reference model
// predicts every cycle's outputs, a monitor compares them after each edge.
module tb_glitch_injector_multi;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned BUS_W    = WIDTH * CHANNELS;
  localparam logic [31:0] SEED     = 32'd17;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [BUS_W-1:0]  in_v = '0;
  logic [BUS_W-1:0]  out_w;
  logic [1:0]        mode_v = '0;
  logic [1:0]        sel_v = '0;
  logic [7:0]        mask_v = '0;
  logic [15:0]       delay_v = '0;
  logic [15:0]       dur_v = '0;
  logic [7:0]        rep_v = '0;
  logic              arm_v = 1'b0;
  logic              trig_v = 1'b0;
  logic              abort_v = 1'b0;
  logic              busy_w, inj_w, done_w;
  logic [15:0]       cnt_w;

  int checks = 0;
  int errors = 0;

  glitch_injector_multi #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEED(17), .CNT_W(CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in           (in_v),
    .out          (out_w),
    .mode         (mode_v),
    .chan_sel     (sel_v),
    .mask         (mask_v),
    .delay        (delay_v),
    .duration     (dur_v),
    .repeats      (rep_v),
    .arm          (arm_v),
    .trigger      (trig_v),
    .abort        (abort_v),
    .busy         (busy_w),
    .injecting    (inj_w),
    .done         (done_w),
    .glitch_count (cnt_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS_W-1:0] out;
    logic             busy;
    logic             inj;
    logic             done;
    logic [15:0]      cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: phase 0 idle, 1 armed, 2 running since trigger edge m_t.
  int          cyc;
  int          m_phase;
  int          m_t;
  int          m_d, m_dur, m_rep;
  logic [1:0]  m_mode;
  logic [1:0]  m_sel;
  logic [7:0]  m_mask;
  logic        m_inj;
  int          m_cnt;
  logic [31:0] m_lfsr;

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc     = 0;
    m_phase = 0;
    m_inj   = 1'b0;
    m_cnt   = 0;
    m_mode  = 2'd0;
    m_sel   = 2'd0;
    m_mask  = 8'd0;
    m_lfsr  = (SEED == 32'd0) ? 32'd1 : SEED;
  endtask

  // Predict outputs after the coming rising edge from the inputs now applied.
  task automatic model_edge();
    exp_t x;
    int   k, p;
    logic [7:0] din, dout;
    logic hit;
    cyc++;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      din = 8'(in_v >> (c * WIDTH));
      hit = m_inj && m_sel[c];
      case (m_mode)
        2'd1:    dout = hit ? (din ^ m_lfsr[7:0]) : din;
        2'd2:    dout = hit ? (din ^ m_mask) : din;
        2'd3:    dout = hit ? m_mask : din;
        default: dout = din;
      endcase
      x.out[c*WIDTH +: WIDTH] = dout;
    end
    x.busy = (m_phase != 0) && !abort_v;
    x.inj  = 1'b0;
    x.done = 1'b0;
    if (m_phase == 2 && !abort_v) begin
      p = m_d + m_dur;
      k = cyc - m_t - 1 - m_d;
      x.inj  = (k >= 0) && (k < (m_rep - 1) * p + m_dur) && ((k % p) < m_dur);
      x.done = (cyc == m_t + m_rep * p + 1);
    end
    if (abort_v) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (arm_v) begin
          m_mode  = mode_v;
          m_sel   = sel_v;
          m_mask  = mask_v;
          m_d     = int'(delay_v);
          m_dur   = (dur_v == 16'd0) ? 1 : int'(dur_v);
          m_rep   = (rep_v == 8'd0) ? 1 : int'(rep_v);
          m_cnt   = 0;
          m_phase = 1;
        end
        1: if (trig_v) begin
          m_phase = 2;
          m_t     = cyc;
        end
        default: if (x.done) m_phase = 0;
      endcase
    end
    if (x.inj && m_cnt < 65535) m_cnt++;
    x.cnt  = 16'(m_cnt);
    m_inj  = x.inj;
    m_lfsr = lstep(m_lfsr);
    exp_q.push_back(x);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic arm_cfg(input logic [1:0] md, input logic [1:0] sel, input logic [7:0] mk,
                         input logic [15:0] d, input logic [15:0] du, input logic [7:0] r);
    mode_v = md; sel_v = sel; mask_v = mk; delay_v = d; dur_v = du; rep_v = r;
    arm_v = 1'b1;
    step();
    arm_v = 1'b0;
  endtask

  task automatic fire();
    trig_v = 1'b1;
    step();
    trig_v = 1'b0;
  endtask

  // Monitor: the DUT presents a fresh output word after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out", 32'(out_w), 32'(e.out));
        check("busy", 32'(busy_w), 32'(e.busy));
        check("injecting", 32'(inj_w), 32'(e.inj));
        check("done", 32'(done_w), 32'(e.done));
        check("glitch_count", 32'(cnt_w), 32'(e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached with %0d expectations pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_out", 32'(out_w), 32'd0);
    check("reset_busy", 32'(busy_w), 32'd0);
    check("reset_count", 32'(cnt_w), 32'd0);
    reset = 1'b0;

    // Passthrough with no arm.
    in_v = 16'hAA55;
    step();
    check("pass_out", 32'(out_w), 32'h0000_AA55);
    check("pass_busy", 32'(busy_w), 32'd0);

    // Mask XOR on channel 0, delay 3, duration 2.
    in_v = 16'h33AA;
    arm_cfg(2'd2, 2'b01, 8'hFF, 16'd3, 16'd2, 8'd1);
    fire();
    run(5);
    check("xor_out_t5", 32'(out_w), 32'h0000_3355);
    step();
    check("xor_out_t6", 32'(out_w), 32'h0000_3355);
    check("xor_done_t6", 32'(done_w), 32'd1);
    step();
    check("xor_out_t7", 32'(out_w), 32'h0000_33AA);
    check("xor_count", 32'(cnt_w), 32'd2);

    // Random mode, three single-cycle glitches back to back.
    arm_cfg(2'd1, 2'b11, 8'h00, 16'd0, 16'd1, 8'd3);
    fire();
    for (int i = 0; i < 6; i++) begin
      in_v = 16'($urandom);
      step();
    end
    check("rand_count", 32'(cnt_w), 32'd3);

    // Stuck-at zero on both channels for four cycles.
    in_v = 16'hBEEF;
    arm_cfg(2'd3, 2'b11, 8'h00, 16'd0, 16'd4, 8'd1);
    fire();
    step();
    check("stuck_before", 32'(out_w), 32'h0000_BEEF);
    step();
    check("stuck_first", 32'(out_w), 32'd0);
    run(3);
    check("stuck_last", 32'(out_w), 32'd0);
    step();
    check("stuck_after", 32'(out_w), 32'h0000_BEEF);

    // Abort during INJECT; re-arm while busy must not change the schedule.
    in_v = 16'h1234;
    arm_cfg(2'd2, 2'b10, 8'h0F, 16'd1, 16'd6, 8'd2);
    fire();
    step();
    mode_v = 2'd0; mask_v = 8'h00; arm_v = 1'b1;
    step();
    arm_v = 1'b0;
    step();
    abort_v = 1'b1;
    step();
    abort_v = 1'b0;
    check("abort_inj", 32'(inj_w), 32'd0);
    check("abort_count", 32'(cnt_w), 32'd2);
    run(4);
    check("abort_busy", 32'(busy_w), 32'd0);
    check("abort_count_held", 32'(cnt_w), 32'd2);

    // Asynchronous reset while waiting in DELAY.
    arm_cfg(2'd2, 2'b11, 8'hAA, 16'd5, 16'd2, 8'd1);
    fire();
    run(2);
    #2 reset = 1'b1;
    #1;
    check("areset_out", 32'(out_w), 32'd0);
    check("areset_busy", 32'(busy_w), 32'd0);
    check("areset_inj", 32'(inj_w), 32'd0);
    check("areset_done", 32'(done_w), 32'd0);
    check("areset_count", 32'(cnt_w), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    arm_cfg(2'd2, 2'b01, 8'h0F, 16'd1, 16'd1, 8'd1);
    fire();
    run(4);
    check("post_reset_count", 32'(cnt_w), 32'd1);

    // Randomized traffic, including ignored arm/trigger and sporadic aborts.
    for (int i = 0; i < 400; i++) begin
      in_v    = 16'($urandom);
      mode_v  = 2'($urandom_range(0, 3));
      sel_v   = 2'($urandom_range(0, 3));
      mask_v  = 8'($urandom);
      delay_v = 16'($urandom_range(0, 3));
      dur_v   = 16'($urandom_range(0, 3));
      rep_v   = 8'($urandom_range(0, 3));
      arm_v   = ($urandom_range(0, 5) == 0);
      trig_v  = ($urandom_range(0, 3) == 0);
      abort_v = ($urandom_range(0, 39) == 0);
      step();
    end
    arm_v = 1'b0; trig_v = 1'b0; abort_v = 1'b0;
    run(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/glitch_injector_multi.md
# glitch_injector_multi

Parametrised, multi-channel successor to the single-bus glitch injector. It sits inline on one or more data buses and forwards them through a register stage. On command it corrupts the selected channels during a scheduled window: configurable trigger delay, glitch duration and repeat count, with random, XOR-mask or stuck-at corruption modes. It is the fault-injection source for exercising the dual-core glitch-detection logic.

## Interface
- `WIDTH`, 8: bits per channel; legal range 1–32.
- `CHANNELS`, 2: number of independent buses.
- `SEED`, 17: LFSR seed; a value of 0 is replaced by 1.
- `CNT_W`, 16: width of the delay, duration and counter fields.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in`  in  CHANNELS*WIDTH  data buses; channel c occupies bits [c*WIDTH +: WIDTH].
- `out`  out  CHANNELS*WIDTH  registered, possibly corrupted data.
- `mode`  in  2  corruption mode: 0 pass, 1 random XOR, 2 mask XOR, 3 stuck-at mask.
- `chan_sel`  in  CHANNELS  one-hot or multi-hot channel enable.
- `mask`  in  WIDTH  pattern used by modes 2 and 3.
- `delay`  in  CNT_W  cycles from trigger (or from the end of the previous glitch) to glitch start.
- `duration`  in  CNT_W  glitch length in cycles; 0 is treated as 1.
- `repeats`  in  8  number of glitches per trigger; 0 is treated as 1.
- `arm`  in  1  latch the configuration and arm the block.
- `trigger`  in  1  start the schedule.
- `abort`  in  1  cancel the schedule immediately.
- `busy`  out  1  state is not IDLE.
- `injecting`  out  1  state is INJECT.
- `done`  out  1  single-cycle pulse when the schedule completes.
- `glitch_count`  out  CNT_W  total INJECT cycles since the last arm; saturates at all-ones.

## Operation
- **States:** IDLE, ARMED, DELAY, INJECT, DONE.
- **IDLE:**
  - `arm`=1 → ARMED.
  - In the same cycle, latch `mode`, `chan_sel`, `mask`, `delay`, `duration` and `repeats`, and clear `glitch_count`.
  - `trigger` is ignored in IDLE, including when asserted together with `arm`.
- **ARMED:** `trigger`=1 → DELAY when the latched delay is greater than 0, otherwise straight to INJECT. Load the repeat counter.
- **DELAY:** count the latched delay cycles, then → INJECT.
- **INJECT:**
  - Count the latched duration cycles.
  - At the end, decrement the repeat counter. If repeats remain → DELAY (or INJECT directly when delay is 0); otherwise → DONE.
- **DONE:** one cycle with `done`=1, then → IDLE.
- **Abort:** `abort` has priority in every state; next state is IDLE with no `done` pulse and `glitch_count` held.
- **Ignored inputs:** `arm` outside IDLE and `trigger` outside ARMED have no effect. Configuration inputs are only sampled on arm.
- **Glitch pattern `g` per channel c:** 0 unless `injecting` and `chan_sel[c]`. Otherwise:
  - mode 1: `lfsr[WIDTH-1:0]`
  - mode 2: `mask`
  - mode 3: stuck-at
  - mode 0: 0
- **Output per channel:** modes 0–2 give out_c ← in_c ^ g_c. Mode 3 gives out_c ← `mask` on selected channels during INJECT, otherwise in_c.
- **LFSR:**
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps 32'h8020_0003).
  - Advances every cycle out of reset.
  - All channels share the same LFSR value in a given cycle.
- **Counters:** `glitch_count` increments on each INJECT cycle and saturates at 2^CNT_W−1.

## Timing
- **Reset values:** `out`=0, state IDLE, `busy`/`injecting`/`done`=0, `glitch_count`=0, LFSR=SEED (or 1 when SEED is 0).
- **Latency:** `out` always lags `in` by exactly one cycle; a glitch appears on `out` one cycle after `injecting` rises.
- **Schedule from trigger:** with `trigger` sampled at edge T:
  - `injecting` is high for edges T+1+delay through T+delay+duration.
  - `out` is corrupted on edges T+2+delay through T+1+delay+duration.
- **Repeats:** each repeat adds `delay`+`duration` cycles.
- **`done` timing:** `done` is high for the cycle after the last INJECT cycle.
- **Abort:** abort at edge A → `injecting`=0 after A; `out` returns to clean passthrough at A+1.
- **Reset mid-schedule:** all registers return to their reset values asynchronously; no `done` pulse.

## Structure
- Package `glitch_pkg`:
  - `glitch_mode_e` (PASS, RAND, XOR, STUCK)
  - `glitch_state_e`
  - `LFSR_TAPS` localparam
- Sub-module `glitch_lfsr`: parameter SEED, 32-bit Galois LFSR, ports `clk`, `reset`, `q[31:0]`.
- Top level holds the FSM, the counters and a generate loop over channels.

## Test plan
- **Passthrough:** reset, `in`=16'hAA55, no arm → `out`=16'hAA55 one cycle later; `busy`=0.
- **Mask XOR, channel 0:** arm with mode 2, `chan_sel`=2'b01, `mask`=8'hFF, `delay`=3, `duration`=2, `repeats`=1; trigger at T → `out`[7:0]=8'h55 on edges T+5 and T+6, channel 1 untouched, `done` pulse at T+6, `glitch_count`=2.
- **Repeats, random mode:** mode 1, `repeats`=3, `delay`=0, `duration`=1 → three single-cycle corruptions matching the reference LFSR model, `glitch_count`=3.
- **Stuck-at:** mode 3, `mask`=8'h00, both channels, `duration`=4 → `out`=0 for 4 cycles, then `in` resumes.
- **Abort:** abort during INJECT → `injecting` drops next cycle, no `done` pulse, `glitch_count` frozen; `arm` while busy is ignored.
- **Async reset mid-DELAY:** assert `reset` between edges → all outputs are 0 immediately; a new arm/trigger works normally afterwards.
